// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester, RAM-port and FIFO-status signals for fifo_wr_arbiter.
// The slave modport is the arbiter; the master modport is the requester/consumer side.
interface fifo_wr_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  ram_wenc;
    logic [AW-1:0]         ram_waddr;
    logic [WIDTH-1:0]      ram_wdata;
    logic                  ram_renc;
    logic [AW-1:0]         ram_raddr;
    logic                  rinc;
    logic                  wfull;
    logic                  rempty;
    logic [AW:0]           count;

    modport master (
        output req, req_data, rinc,
        input  gnt, ram_wenc, ram_waddr, ram_wdata, ram_renc, ram_raddr,
               wfull, rempty, count
    );

    modport slave (
        input  req, req_data, rinc,
        output gnt, ram_wenc, ram_waddr, ram_wdata, ram_renc, ram_raddr,
               wfull, rempty, count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that lets NREQ requesters write into one FIFO
// built on an external dual-port RAM; the consumer reads through rinc.
module fifo_wr_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned BW = $clog2(BURST + 1);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q, last_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;
    logic [NREQ-1:0] gnt;
    logic            wr, rd, full, empty;
    logic [WIDTH-1:0] words [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_words
        assign words[i] = bus.req_data[i*WIDTH +: WIDTH];
    end

    // First requester found searching upward from last+1 with wrap.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] last);
        logic [OW-1:0] pick;
        logic [OW-1:0] cand;
        pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            cand = OW'((int'(last) + k) % NREQ);
            if (r[cand]) pick = cand;
        end
        return pick;
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign rd    = bus.rinc & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        gnt     = '0;
        wr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    owner_d = rr_pick(bus.req, last_q);
                    beat_d  = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                wr           = bus.req[owner_q] & ~full;
                gnt[owner_q] = wr;
                if (wr) beat_d = beat_q + BW'(1);
                // A full FIFO with the owner still requesting simply stalls here.
                if (!bus.req[owner_q] || (wr && beat_q == BW'(BURST - 1))) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr) wptr_q <= wptr_q + AW'(1);
            if (rd) rptr_q <= rptr_q + AW'(1);
            case ({wr, rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.gnt       = gnt;
    assign bus.ram_wenc  = wr;
    assign bus.ram_waddr = wptr_q;
    assign bus.ram_wdata = words[owner_q];
    assign bus.ram_renc  = rd;
    assign bus.ram_raddr = rptr_q;
    assign bus.wfull     = full;
    assign bus.rempty    = empty;
    assign bus.count     = count_q;
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO depth in words; power of 2, >= 4.
REQ-003 SHALL have parameter NREQ, default 4, number of write requesters; range 2..8.
REQ-004 SHALL have parameter BURST, default 4, max words one owner writes per grant; range 1..DEPTH.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have rst  input  1  synchronous active-high reset.
REQ-007 SHALL have req  input  NREQ  per-requester word-valid.
REQ-008 SHALL have req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have gnt  output  NREQ  one-hot accept strobe; word i taken in the cycle gnt[i]=1.
REQ-010 SHALL have ram_wenc / ram_waddr / ram_wdata  output  1 / $clog2(DEPTH) / WIDTH  write port to dual_port_RAM.
REQ-011 SHALL have ram_renc / ram_raddr  output  1 / $clog2(DEPTH)  read port to dual_port_RAM; read data comes from the RAM one cycle later.
REQ-012 SHALL have rinc  input  1  consumer read request.
REQ-013 SHALL have wfull, rempty  output  1 each  FIFO status; count  output  $clog2(DEPTH)+1  words stored.

Function
REQ-014 SHALL implement FSM with states IDLE and BURST, plus registered owner, last_owner and beat counter.
REQ-015 In IDLE with any req bit set: SHALL choose the winner round-robin, searching from last_owner+1 upward with wrap; SHALL load owner, clear beat, and enter BURST next cycle; gnt SHALL be 0 in IDLE.
REQ-016 In IDLE with req=0: SHALL stay in IDLE.
REQ-017 In BURST: gnt[owner] SHALL equal req[owner] & ~wfull, combinationally; all other gnt bits SHALL be 0.
REQ-018 On accept: ram_wenc=1, ram_waddr=wptr, ram_wdata=req_data[owner] in the same cycle; wptr and beat SHALL increment.
REQ-019 BURST SHALL return to IDLE, with last_owner<=owner, when the accept making beat=BURST occurs, or in any cycle where req[owner]=0.
REQ-020 When wfull is set in BURST with req[owner]=1: SHALL hold owner and beat (stall, no timeout).
REQ-021 Read: ram_renc=ram_raddr-valid=rinc & ~rempty; ram_raddr=rptr; rptr SHALL increment on read; rinc while rempty SHALL be ignored.
REQ-022 Pointers SHALL wrap modulo DEPTH.
REQ-023 count SHALL be +1 on write only, -1 on read only, and unchanged on simultaneous write and read.
REQ-024 wfull SHALL be (count==DEPTH) and rempty SHALL be (count==0), both decoded from registered count; no same-cycle pass-through (write blocked when full, even if a read occurs that cycle; read blocked when empty, even if a write occurs that cycle).
REQ-025 Minimum arbitration overhead SHALL be exactly one IDLE cycle between consecutive bursts.

Reset
REQ-026 On rst=1 at a clk edge, the block SHALL enter IDLE with owner=0, beat=0, last_owner=NREQ-1 (requester 0 has first priority), wptr=0, rptr=0, count=0.
REQ-027 During and after reset, outputs SHALL be gnt=0, ram_wenc=0, ram_renc=0, wfull=0, rempty=1; RAM contents are not cleared.
REQ-028 Reset asserted mid-burst SHALL abort the burst; words already written SHALL be discarded (count=0).

Verification
REQ-029 Reset, then req=4'b0101 held, BURST=4 -> cycle 1 IDLE; req0 granted 4 beats (waddr 0..3); 1 IDLE cycle; req2 granted 4 beats (waddr 4..7); count=8.
REQ-030 req=4'b1111 held, with a concurrent reader draining -> grant order 0,1,2,3,0; no requester gets two consecutive bursts.
REQ-031 Fill to 16 with no reads -> wfull=1, gnt=0, owner held; one rinc -> count 15 next cycle, then the stalled accept resumes.
REQ-032 Empty FIFO, rinc=1 and a write in the same cycle -> no ram_renc; count=1; rempty=0 next cycle.
REQ-033 count=5, write and read in the same cycle -> count stays 5; pointers wrap from 15 to 0 correctly over 40 words; read data order matches write order.
REQ-034 req1 drops after 2 beats of a burst -> return to IDLE, last_owner=1; assert rst mid-burst -> count=0, rempty=1, gnt=0 next cycle.
